// File: rtl/sync_pkg.sv
// Shared helpers for the input-conditioning bank.
// Holds the minimum chain depth and a ceil-log2 helper.
package sync_pkg;

  localparam int SYNC_MIN_STAGES = 2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_filter_bank_if.sv
// Bundle of per-channel inputs and conditioned outputs.
// The master side drives raw inputs and clears; the slave side is the bank.
interface sync_filter_bank_if #(
  parameter int WIDTH = 4
) ();

  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] event_clr;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] event_flag;

  modport master (
    output din,
    output event_clr,
    input  level,
    input  rise,
    input  fall,
    input  event_flag
  );

  modport slave (
    input  din,
    input  event_clr,
    output level,
    output rise,
    output fall,
    output event_flag
  );

endinterface

// File: rtl/sync_filter_chan.sv
// One channel: sync chain, optional glitch filter,
// edge detection and a sticky event flag.
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 3,
  parameter bit RESET_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic clr,
  output logic level,
  output logic rise,
  output logic fall,
  output logic event_flag
);

  if (STAGES < SYNC_MIN_STAGES) begin : g_chk
    $fatal(1, "sync_filter_chan: STAGES too small");
  end

  logic [STAGES-1:0] stage_q;
  logic [STAGES-1:0] stage_d;
  logic              sync;
  logic              level_dly_q;
  logic              level_dly_d;
  logic              flag_q;
  logic              flag_d;

  assign sync = stage_q[STAGES-1];

  // Plain shift chain; nothing sits between stages.
  always_comb begin
    stage_d = {stage_q[STAGES-2:0], din};
  end

  // Chain registers.
  always_ff @(posedge clk) begin
    if (rst) stage_q <= {STAGES{RESET_VAL}};
    else     stage_q <= stage_d;
  end

  if (FILTER_LEN == 0) begin : g_byp
    assign level = sync;
  end else begin : g_filt
    localparam int CWR = clog2(FILTER_LEN);
    localparam int CW  = (CWR < 1) ? 1 : CWR;
    localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          lvl_q;
    logic          lvl_d;

    // Accept a new level only after it persists;
    // any return to the old level restarts the count.
    always_comb begin
      cnt_d = '0;
      lvl_d = lvl_q;
      if (sync != lvl_q) begin
        if (cnt_q == LAST) lvl_d = sync;
        else               cnt_d = cnt_q + CW'(1);
      end
    end

    // Filter state registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= '0;
        lvl_q <= RESET_VAL;
      end else begin
        cnt_q <= cnt_d;
        lvl_q <= lvl_d;
      end
    end

    assign level = lvl_q;
  end

  assign rise = level & ~level_dly_q;
  assign fall = ~level & level_dly_q;

  // Delayed level for edges; flag set beats clear.
  always_comb begin
    level_dly_d = level;
    flag_d      = flag_q;
    if (rise | fall) flag_d = 1'b1;
    else if (clr)    flag_d = 1'b0;
  end

  // Edge-detect and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_dly_q <= RESET_VAL;
      flag_q      <= 1'b0;
    end else begin
      level_dly_q <= level_dly_d;
      flag_q      <= flag_d;
    end
  end

  assign event_flag = flag_q;

endmodule

// File: rtl/sync_filter_bank.sv
// Bank of WIDTH independent input conditioners.
// Each bit of the bus gets its own channel instance.
module sync_filter_bank
  import sync_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int STAGES     = 2,
  parameter int FILTER_LEN = 3,
  parameter bit RESET_VAL  = 1'b0
) (
  input logic               clk,
  input logic               rst,
  sync_filter_bank_if.slave bus
);

  if (WIDTH < 1 || STAGES < SYNC_MIN_STAGES) begin : g_chk
    $fatal(1, "sync_filter_bank: bad WIDTH/STAGES");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    sync_filter_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN),
      .RESET_VAL  (RESET_VAL)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .din        (bus.din[i]),
      .clr        (bus.event_clr[i]),
      .level      (bus.level[i]),
      .rise       (bus.rise[i]),
      .fall       (bus.fall[i]),
      .event_flag (bus.event_flag[i])
    );
  end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Bench for sync_filter_bank: filtered and bypass configs
// checked against a sample-history reference model.
module tb_sync_filter_bank;

  logic clk;
  logic rst;
  int   n_assert;
  int   n_fail;

  sync_filter_bank_if #(.WIDTH(4)) bus_a ();
  sync_filter_bank_if #(.WIDTH(4)) bus_b ();

  sync_filter_bank #(
    .WIDTH(4), .STAGES(2), .FILTER_LEN(3), .RESET_VAL(1'b0)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  sync_filter_bank #(
    .WIDTH(4), .STAGES(3), .FILTER_LEN(0), .RESET_VAL(1'b0)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: din history per posedge; level flips once the
  // last FILTER_LEN pre-edge sync samples all disagree with it.
  logic [3:0] dh [2][16];
  logic [3:0] m_lvl  [2];
  logic [3:0] m_prev [2];
  logic [3:0] m_flag [2];

  task automatic model_step(
    input int d, input int stg, input int fl, input logic rv,
    input logic r, input logic [3:0] din, input logic [3:0] clr
  );
    logic [3:0] pr, pf, nl;
    bit all;
    if (r) begin
      for (int k = 0; k < 16; k++) dh[d][k] = {4{rv}};
      m_lvl[d]  = {4{rv}};
      m_prev[d] = {4{rv}};
      m_flag[d] = 4'b0;
    end else begin
      pr = m_lvl[d] & ~m_prev[d];
      pf = ~m_lvl[d] & m_prev[d];
      for (int k = 15; k > 0; k--) dh[d][k] = dh[d][k-1];
      dh[d][0] = din;
      for (int c = 0; c < 4; c++) begin
        if (fl == 0) begin
          nl[c] = dh[d][stg-1][c];
        end else begin
          all = 1'b1;
          for (int j = 0; j < fl; j++)
            if (dh[d][stg+j][c] == m_lvl[d][c]) all = 1'b0;
          nl[c] = all ? ~m_lvl[d][c] : m_lvl[d][c];
        end
        if (pr[c] | pf[c]) m_flag[d][c] = 1'b1;
        else if (clr[c])   m_flag[d][c] = 1'b0;
      end
      m_prev[d] = m_lvl[d];
      m_lvl[d]  = nl;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, 2, 3, 1'b0, rst, bus_a.din, bus_a.event_clr);
    model_step(1, 3, 0, 1'b0, rst, bus_b.din, bus_b.event_clr);
  end

  task automatic chk(
    input string tag, input logic [3:0] obs, input logic [3:0] exp
  );
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_level", bus_a.level, m_lvl[0]);
    chk("a_rise", bus_a.rise, m_lvl[0] & ~m_prev[0]);
    chk("a_fall", bus_a.fall, ~m_lvl[0] & m_prev[0]);
    chk("a_flag", bus_a.event_flag, m_flag[0]);
    chk("b_level", bus_b.level, m_lvl[1]);
    chk("b_rise", bus_b.rise, m_lvl[1] & ~m_prev[1]);
    chk("b_fall", bus_b.fall, ~m_lvl[1] & m_prev[1]);
    chk("b_flag", bus_b.event_flag, m_flag[1]);
  endtask

  task automatic step(
    input logic r,
    input logic [3:0] da, input logic [3:0] ca,
    input logic [3:0] db, input logic [3:0] cb
  );
    rst             = r;
    bus_a.din       = da;
    bus_a.event_clr = ca;
    bus_b.din       = db;
    bus_b.event_clr = cb;
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [3:0] da, db, ca, cb, hi;
    n_assert = 0;
    n_fail   = 0;

    // reset with all inputs high on the filtered bank
    repeat (3) begin
      step(1'b1, 4'hF, 4'h0, 4'h0, 4'h0);
      chk("rst_level", bus_a.level, 4'h0);
      chk("rst_rise", bus_a.rise, 4'h0);
      chk("rst_flag", bus_a.event_flag, 4'h0);
    end
    repeat (4) step(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    chk("rel_level_p4", bus_a.level, 4'h0);
    step(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    chk("rel_level_p5", bus_a.level, 4'hF);
    chk("rel_rise_p5", bus_a.rise, 4'hF);
    step(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
    chk("rel_rise_p6", bus_a.rise, 4'h0);
    chk("rel_flag_p6", bus_a.event_flag, 4'hF);

    // return low and clear flags
    repeat (8) step(1'b0, 4'h0, 4'hF, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("cleared_flag", bus_a.event_flag, 4'h0);

    // glitch on ch0: two samples high
    repeat (2) step(1'b0, 4'h1, 4'h0, 4'h0, 4'h0);
    repeat (6) begin
      step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("glitch_lvl", bus_a.level & 4'h1, 4'h0);
      chk("glitch_flag", bus_a.event_flag & 4'h1, 4'h0);
    end

    // stable pulse on ch1 for 10 cycles
    hi = 4'h0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'h2, 4'h0, 4'h0, 4'h0);
      if (i == 4) chk("pulse_rise", bus_a.rise, 4'h2);
      if (bus_a.level[1]) hi = hi + 4'h1;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      if (i == 4) chk("pulse_fall", bus_a.fall, 4'h2);
      if (bus_a.level[1]) hi = hi + 4'h1;
    end
    chk("pulse_len", hi, 4'd10);

    // filter restart on ch2
    repeat (2) step(1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    repeat (4) step(1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    chk("restart_p4", bus_a.level, 4'h0);
    step(1'b0, 4'h4, 4'h0, 4'h0, 4'h0);
    chk("restart_p5", bus_a.level, 4'h4);
    repeat (8) step(1'b0, 4'h0, 4'hF, 4'h0, 4'h0);

    // sticky flag on ch3: clear loses to a coincident rise
    repeat (5) step(1'b0, 4'h8, 4'h0, 4'h0, 4'h0);
    chk("sticky_rise", bus_a.rise, 4'h8);
    step(1'b0, 4'h8, 4'h8, 4'h0, 4'h0);
    chk("sticky_hold", bus_a.event_flag & 4'h8, 4'h8);
    step(1'b0, 4'h8, 4'h8, 4'h0, 4'h0);
    chk("sticky_clr", bus_a.event_flag & 4'h8, 4'h0);
    repeat (8) step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);

    // bypass bank: one-posedge pulse on ch0, later ch3
    step(1'b0, 4'h0, 4'h0, 4'h1, 4'h0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("byp_p2", bus_b.level, 4'h0);
    step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
    chk("byp_lvl_p3", bus_b.level, 4'h1);
    chk("byp_rise_p3", bus_b.rise, 4'h1);
    step(1'b0, 4'h0, 4'h0, 4'h8, 4'h0);
    chk("byp_lvl_p4", bus_b.level, 4'h0);
    chk("byp_fall_p4", bus_b.fall, 4'h1);
    repeat (6) begin
      step(1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      chk("indep_b", (bus_b.rise | bus_b.fall) & 4'h6, 4'h0);
    end

    // randomized traffic on both banks
    da = 4'h0;
    db = 4'h0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0) da = 4'($urandom);
      if ($urandom_range(0, 2) == 0) db = 4'($urandom);
      ca = 4'($urandom) & 4'($urandom);
      cb = 4'($urandom) & 4'($urandom);
      step($urandom_range(0, 99) == 0, da, ca, db, cb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
